alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 21 ++
 rtl/alu_muldiv_iter.sv | 57 +++++
 rtl/alu_seq.sv | 121 ++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and helpers shared by the sequential ALU
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_SUB   = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_NOR   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_MUL   = 4'hB;
  localparam logic [3:0] ALU_MULHU = 4'hC;
  localparam logic [3:0] ALU_DIVU  = 4'hD;
  localparam logic [3:0] ALU_REMU  = 4'hE;
  localparam logic [3:0] ALU_RSVD  = 4'hF;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic logic is_iterative(input logic [3:0] op);
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result valid-ready bus between register read and writeback
interface alu_seq_if #(parameter int WIDTH = 32, parameter int SHW = $clog2(WIDTH));
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUop;
  logic             cn;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             illegal;
  modport master (output in_valid, a, b, ALUop, cn, shamt, out_ready,
                  input in_ready, out_valid, r, zero, overflow, carry, illegal);
  modport slave (input in_valid, a, b, ALUop, cn, shamt, out_ready,
                 output in_ready, out_valid, r, zero, overflow, carry, illegal);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: WIDTH-step shift-add multiplier / restoring divider on one shared accumulator
import alu_pkg::*;
module alu_muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o,
  output logic             ovf_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q;
  logic [3:0] op_q;
  logic [CW-1:0] cnt_q;
  logic busy_q, is_mul;
  logic [WIDTH:0] add_s, rem_s, dif_s;
  // one step: multiply adds the multiplicand into the high half then shifts right;
  // divide shifts the remainder left and keeps the subtraction when it does not borrow
  always_comb begin
    is_mul = op_q == ALU_MUL || op_q == ALU_MULHU;
    add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem_s = acc_q[2*WIDTH-1:WIDTH-1];
    dif_s = rem_s - {1'b0, m_q};
    acc_d = is_mul ? {add_s, acc_q[WIDTH-1:1]}
          : dif_s[WIDTH] ? {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
          : {dif_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end
  assign done_o = busy_q && cnt_q == CW'(WIDTH);
  assign r_o = (op_q == ALU_MULHU || op_q == ALU_REMU) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  assign ovf_o = !is_mul && m_q == '0;
  // load operands on start, iterate exactly WIDTH times, release on done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      op_q   <= ALU_AND;
    end else if (start_i) begin
      acc_q  <= {{WIDTH{1'b0}}, is_iterative(op_i) && op_i inside {ALU_MUL, ALU_MULHU} ? b_i : a_i};
      m_q    <= op_i inside {ALU_MUL, ALU_MULHU} ? a_i : b_i;
      op_q   <= op_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (done_o) busy_q <= 1'b0;
      else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready ALU; define ALU_MULDIV_EN to build the iterative MUL/DIV engine
import alu_pkg::*;
module alu_seq #(parameter int WIDTH = 32, parameter int SHW = $clog2(WIDTH)) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  logic [1:0] state_q;
  logic go_q, cn_q, zero_q, ovf_q, carry_q, ill_q;
  logic ovf_d, carry_d, ill_d, accept;
  logic [WIDTH-1:0] a_q, b_q, r_q, res_d;
  logic [3:0] op_q;
  logic [SHW-1:0] sh_q;
  logic [WIDTH:0] sum, dif;
  logic eng_done, eng_ovf;
  logic [WIDTH-1:0] eng_r;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
  logic start;
  assign start = accept && is_iterative(bus.ALUop);
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(bus.ALUop), .a_i(bus.a), .b_i(bus.b),
    .done_o(eng_done), .r_o(eng_r), .ovf_o(eng_ovf)
  );
`else
  localparam bit MULDIV = 1'b0;
  assign eng_done = 1'b0;
  assign eng_r = '0;
  assign eng_ovf = 1'b0;
`endif
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.in_ready = state_q == ST_IDLE && !go_q;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.r = r_q;
  assign bus.zero = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.carry = carry_q;
  assign bus.illegal = ill_q;
  // single-cycle result from the latched operands; anything unhandled here is illegal
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cn_q};
    dif = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cn_q};
    res_d = '0;
    ovf_d = 1'b0;
    carry_d = 1'b0;
    ill_d = 1'b0;
    case (op_q)
      ALU_AND:  res_d = a_q & b_q;
      ALU_OR:   res_d = a_q | b_q;
      ALU_ADD: begin
        res_d = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d = a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1];
      end
      ALU_SUB: begin
        res_d = dif[WIDTH-1:0];
        carry_d = !dif[WIDTH];
        ovf_d = a_q[WIDTH-1] != b_q[WIDTH-1] && dif[WIDTH-1] != a_q[WIDTH-1];
      end
      ALU_XOR:  res_d = a_q ^ b_q;
      ALU_NOR:  res_d = ~(a_q | b_q);
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
      ALU_SLL:  res_d = a_q << sh_q;
      ALU_SRL:  res_d = a_q >> sh_q;
      ALU_SRA:  res_d = $unsigned($signed(a_q) >>> sh_q);
      default:  ill_d = 1'b1;
    endcase
  end
  // control FSM: accept, compute (one cycle or WIDTH iterations), hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_AND;
      cn_q    <= 1'b0;
      sh_q    <= '0;
    end else begin
      if (accept) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.ALUop;
        cn_q <= bus.cn;
        sh_q <= bus.shamt;
      end
      case (state_q)
        ST_IDLE:
          if (go_q) begin
            state_q <= ST_DONE;
            go_q    <= 1'b0;
            r_q     <= res_d;
            zero_q  <= res_d == '0;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            ill_q   <= ill_d;
          end else if (accept) begin
            if (MULDIV && is_iterative(bus.ALUop)) state_q <= ST_CALC;
            else go_q <= 1'b1;
          end
        ST_CALC:
          if (eng_done) begin
            state_q <= ST_DONE;
            r_q     <= eng_r;
            zero_q  <= eng_r == '0;
            ovf_q   <= eng_ovf;
            carry_q <= 1'b0;
            ill_q   <= 1'b0;
          end
        ST_DONE: if (bus.out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, corner sequences and random ops against a plain-arithmetic model
module tb_alu_seq;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(32)) bus();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef ALU_MULDIV_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] r; logic [3:0] fl; int lat;} exp_t;
  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic cn; logic [4:0] sh; logic [31:0] r; logic [3:0] fl;} vec_t;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cn, input logic [4:0] sh);
    exp_t e;
    longint s, ss;
    logic [63:0] p;
    logic v, c, il;
    e.r = 0; e.lat = 1; v = 0; c = 0; il = 0; s = 0; ss = 0;
    p = {32'h0, a} * {32'h0, b};
    case (op)
      ALU_AND:  e.r = a & b;
      ALU_OR:   e.r = a | b;
      ALU_ADD: begin
        s = longint'(a) + longint'(b) + longint'(cn);
        ss = longint'($signed(a)) + longint'($signed(b)) + longint'(cn);
        e.r = s[31:0]; c = s > 64'd4294967295; v = ss != longint'($signed(ss[31:0]));
      end
      ALU_SUB: begin
        s = longint'(a) - longint'(b) - longint'(cn);
        ss = longint'($signed(a)) - longint'($signed(b)) - longint'(cn);
        e.r = s[31:0]; c = s >= 0; v = ss != longint'($signed(ss[31:0]));
      end
      ALU_XOR:  e.r = a ^ b;
      ALU_NOR:  e.r = ~(a | b);
      ALU_SLT:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  e.r = a << sh;
      ALU_SRL:  e.r = a >> sh;
      ALU_SRA:  e.r = $signed(a) >>> sh;
      ALU_MUL:  e.r = p[31:0];
      ALU_MULHU: e.r = p[63:32];
      ALU_DIVU: begin e.r = (b == 0) ? 32'hFFFF_FFFF : a / b; v = b == 0; end
      ALU_REMU: begin e.r = (b == 0) ? a : a % b; v = b == 0; end
      default: il = 1;
    endcase
    if (is_iterative(op)) begin
      if (EN) e.lat = 33;
      else begin e.r = 0; v = 0; il = 1; end
    end
    e.fl = {e.r == 0, v, c, il};
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cn,
                        input logic [4:0] sh, input logic rdy, output logic [31:0] r, output logic [3:0] fl,
                        output int lat, output logic busy_ok);
    bus.in_valid = 1; bus.ALUop = op; bus.a = a; bus.b = b; bus.cn = cn; bus.shamt = sh; bus.out_ready = rdy;
    busy_ok = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    r = bus.r;
    fl = {bus.zero, bus.overflow, bus.carry, bus.illegal};
    if (rdy) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] r, xr;
    logic [3:0] fl, xfl, op;
    logic [31:0] a, b;
    logic cn, busy_ok;
    logic [4:0] sh;
    int lat;
    exp_t e;
    tbl[0]  = '{ALU_OR,   32'd50, 32'd40, 1'b0, 5'd0, 32'd58, 4'b0000};
    tbl[1]  = '{ALU_ADD,  32'd100, 32'd50, 1'b0, 5'd0, 32'd150, 4'b0000};
    tbl[2]  = '{ALU_SUB,  32'd3, 32'd3, 1'b0, 5'd0, 32'd0, 4'b1010};
    tbl[3]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 1'b0, 5'd0, 32'h8000_0000, 4'b0100};
    tbl[4]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd1, 4'b0000};
    tbl[5]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd0, 4'b1000};
    tbl[6]  = '{ALU_SRA,  32'h8000_0000, 32'd0, 1'b0, 5'd4, 32'hF800_0000, 4'b0000};
    tbl[7]  = '{ALU_SLL,  32'd1, 32'd0, 1'b0, 5'd31, 32'h8000_0000, 4'b0000};
    tbl[8]  = '{ALU_RSVD, 32'd5, 32'd6, 1'b0, 5'd0, 32'd0, 4'b1001};
    tbl[9]  = '{ALU_MUL,  32'd50, 32'd40, 1'b0, 5'd0, 32'd2000, 4'b0000};
    tbl[10] = '{ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hFFFF_FFFE, 4'b0000};
    tbl[11] = '{ALU_DIVU, 32'd100, 32'd7, 1'b0, 5'd0, 32'd14, 4'b0000};
    tbl[12] = '{ALU_REMU, 32'd100, 32'd7, 1'b0, 5'd0, 32'd2, 4'b0000};
    tbl[13] = '{ALU_DIVU, 32'd12345, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFFF, 4'b0100};
    tbl[14] = '{ALU_REMU, 32'd9, 32'd0, 1'b0, 5'd0, 32'd9, 4'b0100};
    tbl[15] = '{ALU_ADD,  32'hFFFF_FFFF, 32'd0, 1'b1, 5'd0, 32'd0, 4'b1010};
    tbl[16] = '{ALU_SUB,  32'd0, 32'd1, 1'b0, 5'd0, 32'hFFFF_FFFF, 4'b0000};
    tbl[17] = '{ALU_SUB,  32'd5, 32'd2, 1'b1, 5'd0, 32'd2, 4'b0010};
    tbl[18] = '{ALU_NOR,  32'd0, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFFF, 4'b0000};
    tbl[19] = '{ALU_SRL,  32'h8000_0000, 32'd0, 1'b0, 5'd31, 32'd1, 4'b0000};
    tbl[20] = '{ALU_XOR,  32'hFF, 32'h0F, 1'b0, 5'd0, 32'hF0, 4'b0000};
    tbl[21] = '{ALU_AND,  32'hF0F0, 32'hFF00, 1'b0, 5'd0, 32'hF000, 4'b0000};
    tbl[22] = '{ALU_MUL,  32'd0, 32'd12345, 1'b0, 5'd0, 32'd0, 4'b1000};
    bus.in_valid = 0; bus.out_ready = 1; bus.a = 0; bus.b = 0; bus.ALUop = 0; bus.cn = 0; bus.shamt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_r", bus.r, 32'd0);
    chk("reset_flags", 32'({bus.zero, bus.overflow, bus.carry, bus.illegal}), 32'd0);
    rst_n = 1;
    for (int i = 0; i < 23; i++) begin
      xr = tbl[i].r;
      xfl = tbl[i].fl;
      if (is_iterative(tbl[i].op) && !EN) begin xr = 0; xfl = 4'b1001; end
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cn, tbl[i].sh, 1'b1, r, fl, lat, busy_ok);
      chk($sformatf("vec%0d_r", i), r, xr);
      chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(xfl));
      chk($sformatf("vec%0d_latency", i), lat, (is_iterative(tbl[i].op) && EN) ? 33 : 1);
      chk($sformatf("vec%0d_in_ready_low", i), 32'(busy_ok), 32'd1);
    end
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h10, 1'b0, 5'd0, 1'b0, r, fl, lat, busy_ok);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_r", bus.r, 32'h8000_000F);
      chk("hold_flags", 32'({bus.zero, bus.overflow, bus.carry, bus.illegal}), 32'b0100);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(ALU_OR, 32'h1234_0000, 32'h5678, 1'b0, 5'd0, 1'b1, r, fl, lat, busy_ok);
    chk("pre_reset_r", r, 32'h1234_5678);
    bus.in_valid = 1; bus.ALUop = ALU_MUL; bus.a = 50; bus.b = 40; bus.out_ready = 0;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 0;
    @(posedge clk); #1;
    chk("midop_reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midop_reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midop_reset_r", bus.r, 32'd0);
    chk("midop_reset_flags", 32'({bus.zero, bus.overflow, bus.carry, bus.illegal}), 32'd0);
    rst_n = 1; bus.out_ready = 1;
    e = model(ALU_DIVU, 32'd100, 32'd7, 1'b0, 5'd0);
    run_op(ALU_DIVU, 32'd100, 32'd7, 1'b0, 5'd0, 1'b1, r, fl, lat, busy_ok);
    chk("after_reset_r", r, e.r);
    chk("after_reset_latency", lat, e.lat);
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
      cn = 1'($urandom_range(0, 1));
      sh = 5'($urandom_range(0, 31));
      e = model(op, a, b, cn, sh);
      run_op(op, a, b, cn, sh, 1'b1, r, fl, lat, busy_ok);
      chk($sformatf("rnd%0d_op%0d_r", i, op), r, e.r);
      chk($sformatf("rnd%0d_op%0d_flags", i, op), 32'(fl), 32'(e.fl));
      chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, e.lat);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
